// File: rtl/tb_engine_if.sv
// Op stream between the traceback engine and its consumer.
// The engine drives the master side; the consumer drives op_ready from the slave side.
interface tb_engine_if;
    logic [1:0] op_o;
    logic       op_valid;
    logic       op_ready;
    logic       done;

    modport master (output op_o, output op_valid, output done, input op_ready);
    modport slave  (input op_o, input op_valid, input done, output op_ready);
endinterface

// File: rtl/tb_engine.sv
// Traceback engine: walks the direction memory of a finished DP score matrix from an
// end cell back to its origin and emits one alignment op per step on a valid/ready stream.
// Optional feature macro: TB_LEN_COUNT_EN adds a saturating 16-bit count of the
// non-end ops accepted in the current walk (len_o).
module tb_engine #(
    parameter int N                = 4,
    parameter int DIRECTION_WIDTH  = 2,
    parameter int MEM_AMOUNT_WIDTH = 2,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int PE_WIDTH         = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset_i,
    input  logic                          tb_valid,
    input  logic                          array_num,
    input  logic [MEM_AMOUNT_WIDTH-1:0]   start_block,
    input  logic [ADDRESS_WIDTH-1:0]      start_row,
    input  logic [PE_WIDTH-1:0]           start_pe,
    output logic                          tb_busy,
    output logic [MEM_AMOUNT_WIDTH-1:0]   mem_block_num,
    output logic [ADDRESS_WIDTH-1:0]      row_num,
    input  logic [N*DIRECTION_WIDTH-1:0]  row_k0,
    input  logic [N*DIRECTION_WIDTH-1:0]  row_k1,
    output logic                          tb_array_o,
    tb_engine_if.master                   op_if
`ifdef TB_LEN_COUNT_EN
    ,
    output logic [15:0]                   len_o
`endif
);

    localparam logic [1:0] OP_END  = 2'b00;
    localparam logic [1:0] OP_DIAG = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_LEFT = 2'b11;
    localparam logic [PE_WIDTH-1:0] PE_LAST = PE_WIDTH'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                          r_state, w_state_nxt;

    // Current walk position (block, row, lane) and the address presented to memory.
    logic [MEM_AMOUNT_WIDTH-1:0]     r_blk;
    logic [ADDRESS_WIDTH-1:0]        r_row;
    logic [PE_WIDTH-1:0]             r_pe;
    logic [MEM_AMOUNT_WIDTH-1:0]     r_mem_blk;
    logic [ADDRESS_WIDTH-1:0]        r_mem_row;

    logic [N*DIRECTION_WIDTH-1:0]    r_cache_k0;
    logic [N*DIRECTION_WIDTH-1:0]    r_cache_k1;
    logic                            r_cache_vld;
    logic                            r_force_end;
    logic                            r_array;
    logic [1:0]                      r_op;

    logic [DIRECTION_WIDTH-1:0]      w_code;
    logic                            w_hs;
    logic                            w_row_zero;
    logic                            w_origin;

    assign w_code     = r_cache_k0[r_pe*DIRECTION_WIDTH +: DIRECTION_WIDTH];
    assign w_hs       = (r_state == S_EMIT) && op_if.op_ready;
    assign w_row_zero = (r_row == '0);
    // Lane 0 of block 0: nothing further left exists in this matrix.
    assign w_origin   = (r_blk == '0) && (r_pe == '0);

    assign tb_busy        = (r_state != S_IDLE);
    assign op_if.op_valid = (r_state == S_EMIT);
    assign op_if.done     = (r_state == S_DONE);
    assign op_if.op_o     = r_op;
    assign mem_block_num  = r_mem_blk;
    assign row_num        = r_mem_row;
    assign tb_array_o     = r_array;

    // State register.
    always_ff @(posedge clk) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state: a boundary step stays in DECODE so the forced end op needs no fetch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (tb_valid) w_state_nxt = S_FETCH;
            S_FETCH:  w_state_nxt = S_WAIT;
            S_WAIT:   w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (w_hs) begin
                    case (r_op)
                        OP_END:  w_state_nxt = S_DONE;
                        OP_DIAG: w_state_nxt = (w_row_zero || w_origin) ? S_DECODE : S_FETCH;
                        OP_UP:   w_state_nxt = w_row_zero ? S_DECODE : S_FETCH;
                        default: w_state_nxt = S_DECODE;
                    endcase
                end
            end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Position, cache and op datapath, advanced by the FSM phase.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_blk       <= '0;
            r_row       <= '0;
            r_pe        <= '0;
            r_mem_blk   <= '0;
            r_mem_row   <= '0;
            r_cache_k0  <= '0;
            r_cache_k1  <= '0;
            r_cache_vld <= 1'b0;
            r_force_end <= 1'b0;
            r_array     <= 1'b0;
            r_op        <= OP_END;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (tb_valid) begin
                        r_array     <= array_num;
                        r_blk       <= start_block;
                        r_row       <= start_row;
                        r_pe        <= start_pe;
                        r_mem_blk   <= start_block;
                        r_mem_row   <= start_row;
                        r_cache_vld <= 1'b0;
                        r_force_end <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_cache_k0  <= row_k0;
                    r_cache_k1  <= row_k1;
                    r_cache_vld <= 1'b1;
                end
                S_DECODE: begin
                    r_op <= (r_force_end || !r_cache_vld) ? OP_END : w_code[1:0];
                end
                S_EMIT: begin
                    if (w_hs) begin
                        case (r_op)
                            OP_DIAG: begin
                                if (w_row_zero || w_origin) begin
                                    r_force_end <= 1'b1;
                                end else begin
                                    r_row     <= r_row - 1'b1;
                                    r_mem_row <= r_row - 1'b1;
                                    if (r_pe == '0) begin
                                        r_blk     <= r_blk - 1'b1;
                                        r_mem_blk <= r_blk - 1'b1;
                                        r_pe      <= PE_LAST;
                                    end else begin
                                        r_mem_blk <= r_blk;
                                        r_pe      <= r_pe - 1'b1;
                                    end
                                end
                            end
                            OP_UP: begin
                                if (w_row_zero) begin
                                    r_force_end <= 1'b1;
                                end else begin
                                    r_row     <= r_row - 1'b1;
                                    r_mem_row <= r_row - 1'b1;
                                    r_mem_blk <= r_blk;
                                end
                            end
                            OP_LEFT: begin
                                // Left steps stay within the cached row; crossing into
                                // block K-1 promotes its copy (only one crossing is cached).
                                if (w_origin) begin
                                    r_force_end <= 1'b1;
                                end else if (r_pe != '0) begin
                                    r_pe <= r_pe - 1'b1;
                                end else begin
                                    r_blk      <= r_blk - 1'b1;
                                    r_pe       <= PE_LAST;
                                    r_cache_k0 <= r_cache_k1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_DONE: begin
                    r_cache_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef TB_LEN_COUNT_EN
    logic [15:0] r_len;
    assign len_o = r_len;

    // Alignment length: accepted non-end ops, saturating, held until the next walk starts.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_len <= '0;
        end else if ((r_state == S_IDLE) && tb_valid) begin
            r_len <= '0;
        end else if (w_hs && (r_op != OP_END) && (r_len != 16'hFFFF)) begin
            r_len <= r_len + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tb_engine.sv
// Directed bench for tb_engine (N=4, 2-bit codes, 4 blocks x 16 rows).
module tb_tb_engine;
    localparam int N  = 4;
    localparam int DW = 2;
    localparam int MW = 2;
    localparam int AW = 4;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            reset_i;
    logic            tb_valid;
    logic            array_num;
    logic [MW-1:0]   start_block;
    logic [AW-1:0]   start_row;
    logic [PW-1:0]   start_pe;
    logic            tb_busy;
    logic [MW-1:0]   mem_block_num;
    logic [AW-1:0]   row_num;
    logic [N*DW-1:0] row_k0;
    logic [N*DW-1:0] row_k1;
    logic            tb_array_o;
`ifdef TB_LEN_COUNT_EN
    logic [15:0]     len_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [N*DW-1:0] mem [4][16];
    logic [MW-1:0]   w_km1;

    always #5 clk = ~clk;

    tb_engine_if u_if ();

    tb_engine #(
        .N(N), .DIRECTION_WIDTH(DW), .MEM_AMOUNT_WIDTH(MW), .ADDRESS_WIDTH(AW), .PE_WIDTH(PW)
    ) dut (
        .clk(clk),
        .reset_i(reset_i),
        .tb_valid(tb_valid),
        .array_num(array_num),
        .start_block(start_block),
        .start_row(start_row),
        .start_pe(start_pe),
        .tb_busy(tb_busy),
        .mem_block_num(mem_block_num),
        .row_num(row_num),
        .row_k0(row_k0),
        .row_k1(row_k1),
        .tb_array_o(tb_array_o),
        .op_if(u_if)
`ifdef TB_LEN_COUNT_EN
        ,
        .len_o(len_o)
`endif
    );

    // Direction memory: one-cycle read latency, block K and block K-1 side by side.
    assign w_km1 = mem_block_num - 2'd1;
    always @(posedge clk) begin
        row_k0 <= mem[mem_block_num][row_num];
        row_k1 <= mem[w_km1][row_num];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int b = 0; b < 4; b++)
            for (int r = 0; r < 16; r++)
                mem[b][r] = '0;
    endtask

    // Called at a negedge; returns at the negedge after tb_valid was sampled.
    task automatic start_walk(input logic arr, input logic [MW-1:0] b,
                              input logic [AW-1:0] r, input logic [PW-1:0] p);
        array_num = arr; start_block = b; start_row = r; start_pe = p; tb_valid = 1'b1;
        @(negedge clk);
        tb_valid = 1'b0; array_num = 1'b0;
    endtask

    // Waits (bounded) for op_valid, checks op, wait count and address; optionally accepts.
    task automatic expect_op(input string tag, input logic [1:0] eop, input int ew,
                             input logic [MW-1:0] eb, input logic [AW-1:0] er, input bit accept);
        int w;
        w = 0;
        while (!u_if.op_valid && w < 16) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_valid"}, 32'(u_if.op_valid), 32'd1);
        chk({tag, "_op"},    32'(u_if.op_o), 32'(eop));
        chk({tag, "_lat"},   32'(w), 32'(ew));
        chk({tag, "_blk"},   32'(mem_block_num), 32'(eb));
        chk({tag, "_row"},   32'(row_num), 32'(er));
        if (accept) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  32'(tb_busy), 32'd0);
        chk({tag, "_valid"}, 32'(u_if.op_valid), 32'd0);
        chk({tag, "_done"},  32'(u_if.done), 32'd0);
        chk({tag, "_op"},    32'(u_if.op_o), 32'd0);
        chk({tag, "_blk"},   32'(mem_block_num), 32'd0);
        chk({tag, "_row"},   32'(row_num), 32'd0);
        chk({tag, "_arr"},   32'(tb_array_o), 32'd0);
    endtask

    initial begin
        reset_i = 1'b1; tb_valid = 1'b0; array_num = 1'b0;
        start_block = '0; start_row = '0; start_pe = '0;
        u_if.op_ready = 1'b1;
        clear_mem();
        repeat (2) @(negedge clk);
        chk_idle_outputs("por");
`ifdef TB_LEN_COUNT_EN
        chk("por_len", 32'(len_o), 32'd0);
`endif
        reset_i = 1'b0;
        @(negedge clk);

        // Left-walk matrix: block1 row2 all left, block0 row2 lane3 up, block0 row1 lane3 stop.
        mem[1][2] = 8'hFF;
        mem[0][2] = 8'hBF;
        mem[0][1] = 8'h3F;

        // Reset in the middle of a walk.
        start_walk(1'b1, 2'd1, 4'd2, 2'd3);
        expect_op("rst_op0", 2'b11, 3, 2'd1, 4'd2, 1'b0);
        reset_i = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst1");
        @(negedge clk);
        chk_idle_outputs("rst2");
        reset_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", 32'(u_if.done), 32'd0);
            chk("rst_no_busy", 32'(tb_busy), 32'd0);
        end

        // Left steps within a row, then a block crossing using the K-1 copy.
        start_walk(1'b0, 2'd1, 4'd2, 2'd3);
        expect_op("left0", 2'b11, 3, 2'd1, 4'd2, 1'b1);
        expect_op("left1", 2'b11, 1, 2'd1, 4'd2, 1'b1);
        expect_op("left2", 2'b11, 1, 2'd1, 4'd2, 1'b1);
        expect_op("left3", 2'b11, 1, 2'd1, 4'd2, 1'b1);
        expect_op("cross", 2'b10, 1, 2'd1, 4'd2, 1'b1);
        expect_op("lend",  2'b00, 3, 2'd0, 4'd1, 1'b1);
        chk("left_done", 32'(u_if.done), 32'd1);
`ifdef TB_LEN_COUNT_EN
        chk("left_len", 32'(len_o), 32'd5);
`endif
        @(negedge clk);
        chk("left_idle", 32'(tb_busy), 32'd0);

        // Diagonal chain (0,3,3) -> (0,0,0).
        clear_mem();
        mem[0][3] = 8'h7F;
        mem[0][2] = 8'hDF;
        mem[0][1] = 8'hF7;
        mem[0][0] = 8'hFC;
        start_walk(1'b1, 2'd0, 4'd3, 2'd3);
        chk("diag_busy", 32'(tb_busy), 32'd1);
        chk("diag_arr",  32'(tb_array_o), 32'd1);
        expect_op("diag0", 2'b01, 3, 2'd0, 4'd3, 1'b1);
        expect_op("diag1", 2'b01, 3, 2'd0, 4'd2, 1'b1);
        expect_op("diag2", 2'b01, 3, 2'd0, 4'd1, 1'b1);
        expect_op("diag3", 2'b00, 3, 2'd0, 4'd0, 1'b1);
        chk("diag_done", 32'(u_if.done), 32'd1);
        chk("diag_busy_done", 32'(tb_busy), 32'd1);
`ifdef TB_LEN_COUNT_EN
        chk("diag_len", 32'(len_o), 32'd3);
`endif
        @(negedge clk);
        chk("diag_done_pulse", 32'(u_if.done), 32'd0);
        chk("diag_busy_after", 32'(tb_busy), 32'd0);
        chk("diag_arr_hold", 32'(tb_array_o), 32'd1);
`ifdef TB_LEN_COUNT_EN
        chk("diag_len_hold", 32'(len_o), 32'd3);
`endif

        // Back-pressure for 5 cycles plus an ignored tb_valid while busy.
        start_walk(1'b0, 2'd0, 4'd3, 2'd3);
        expect_op("bp0", 2'b01, 3, 2'd0, 4'd3, 1'b1);
        u_if.op_ready = 1'b0;
        expect_op("bp1", 2'b01, 3, 2'd0, 4'd2, 1'b0);
        array_num = 1'b1; start_block = 2'd3; start_row = 4'd9; start_pe = 2'd0; tb_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tb_valid = 1'b0; array_num = 1'b0;
            chk("bp_hold_valid", 32'(u_if.op_valid), 32'd1);
            chk("bp_hold_op",    32'(u_if.op_o), 32'd1);
            chk("bp_hold_row",   32'(row_num), 32'd2);
            chk("bp_hold_blk",   32'(mem_block_num), 32'd0);
            chk("bp_arr",        32'(tb_array_o), 32'd0);
        end
        u_if.op_ready = 1'b1;
        @(negedge clk);
        expect_op("bp2", 2'b01, 3, 2'd0, 4'd1, 1'b1);
        expect_op("bp3", 2'b00, 3, 2'd0, 4'd0, 1'b1);
        chk("bp_done", 32'(u_if.done), 32'd1);
        chk("bp_arr_end", 32'(tb_array_o), 32'd0);
        @(negedge clk);
        chk("bp_idle", 32'(tb_busy), 32'd0);

        // Boundary: up from row 0 forces an end op without a fetch.
        clear_mem();
        mem[0][0] = 8'hFB;
        mem[0][2] = 8'hFD;
        start_walk(1'b0, 2'd0, 4'd0, 2'd1);
        expect_op("up0_op", 2'b10, 3, 2'd0, 4'd0, 1'b1);
        expect_op("up0_end", 2'b00, 1, 2'd0, 4'd0, 1'b1);
        chk("up0_done", 32'(u_if.done), 32'd1);
`ifdef TB_LEN_COUNT_EN
        chk("up0_len", 32'(len_o), 32'd1);
`endif
        @(negedge clk);

        // Boundary: diag at block 0 lane 0 forces an end op, address untouched.
        start_walk(1'b0, 2'd0, 4'd2, 2'd0);
        expect_op("org_op", 2'b01, 3, 2'd0, 4'd2, 1'b1);
        expect_op("org_end", 2'b00, 1, 2'd0, 4'd2, 1'b1);
        chk("org_done", 32'(u_if.done), 32'd1);
        @(negedge clk);
        chk("org_idle", 32'(tb_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
